zapper_port_ctrl: RTL
=====================

Name: zapper_port_ctrl

Overview:
- Controller-port sequencer for the $4016/$4017 input path. Implements the strobe/latch/shift protocol for two standard joypads.
- When the light gun is enabled, it substitutes zapper light and trigger status on the port-2 read bits.
- It also arbitrates which host input source (mouse or analog stick) drives the zapper's aim. It drives the zapper's `mode` select and sits between the CPU register decode and the zapper/joypad inputs.

Parameters:
- HOLD_CYCLES, 1_000_000, idle clocks the current aim owner must be quiet before ownership may transfer (simulation overrides to a small value).
- CNT_W, 20, width of the idle counter; must hold HOLD_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_wr_4016  in  1  one-clock pulse: CPU write to $4016
- cpu_din0  in  1  data bit 0 of that write (strobe value)
- cpu_rd_4016  in  1  one-clock pulse: CPU read of $4016
- cpu_rd_4017  in  1  one-clock pulse: CPU read of $4017
- joy1  in  8  port-1 buttons, 1=pressed, bit0=A … bit7=Right
- joy2  in  8  port-2 buttons, same order
- zap_en  in  1  zapper plugged into port 2
- zap_light  in  1  zapper light bit, 0 = light sensed
- zap_trigger  in  1  zapper trigger bit, 1 = pulled
- mouse_act  in  1  one-clock pulse on each new mouse packet with nonzero motion
- stick_act  in  1  level: analog stick outside deadzone
- zap_mode  out  1  aim source to zapper: 0 = mouse, 1 = analog stick
- dout_4016  out  5  read data for $4016, bits [4:0]
- dout_4017  out  5  read data for $4017, bits [4:0]

Behaviour:

Reset values:
- strobe=0, sh1=sh2=8'hFF, rd counters=0.
- dout_4016=dout_4017=5'b00000, zap_mode=0, arbiter state OWN_MOUSE, idle counter=0.

Strobe:
- On cpu_wr_4016, strobe <= cpu_din0.
- While strobe=1 (registered value), sh1<=joy1 and sh2<=joy2 every clock, and rd counters are cleared.
- The strobe 1→0 transition leaves the last-loaded values latched.

Reads:
- On cpu_rd_4016 with strobe=0: dout_4016[0] <= sh1[0]; sh1 <= {1'b1, sh1[7:1]}; rd1 counter +1, saturating at 8.
- On cpu_rd_4016 with strobe=1: dout_4016[0] <= joy1[0]; no shift.
- cpu_rd_4017 behaves identically using sh2/joy2 when zap_en=0.
- After 8 shifting reads, bit0 returns 1 indefinitely.
- Latency: dout valid the clock after the read pulse and held until the next read of that register.
- dout bits [2:1] are always 0.
- dout_4016 bits [4:3] are always 0.

Zapper substitution (zap_en=1):
- On cpu_rd_4017: dout_4017 <= {zap_trigger, zap_light, 3'b000}. sh2 neither loads nor shifts.
- When zap_en=0: dout_4017[4:3]=0.
- Changing zap_en takes effect on the next read; no reset of sh2 is required.

Simultaneous events:
- A read in the same clock as a $4016 write uses the pre-write strobe value.
- Simultaneous reads of $4016 and $4017 are handled independently.

Aim arbiter FSM (states OWN_MOUSE, OWN_STICK; zap_mode = (state==OWN_STICK), registered):
- OWN_MOUSE: mouse_act clears the idle counter; otherwise the counter increments, saturating at HOLD_CYCLES. If stick_act=1 and counter==HOLD_CYCLES, go to OWN_STICK and clear the counter.
- OWN_STICK: stick_act=1 clears the idle counter; otherwise the counter increments, saturating. If mouse_act=1 and counter==HOLD_CYCLES, go to OWN_MOUSE and clear the counter.
- Activity from the owner in the same clock as a transfer condition: the owner keeps the resource (clear has priority).
- Reset mid-hold returns to OWN_MOUSE with counter 0.

Test Plan:
1. joy1=8'b1000_0101; write $4016 1 then 0; 10 reads of $4016 → bit0 sequence 1,0,1,0,0,0,0,1,1,1.
2. strobe=1, joy1[0] toggles between reads; 3 reads → each returns the current joy1[0], and after strobe→0 the first read returns the joy1[0] present at the falling write.
3. zap_en=1, zap_light=0, zap_trigger=1, joy2=8'hFF; 3 reads of $4017 → dout_4017=5'b10000 each time; then zap_en=0 with re-strobe → bit0=1, bits[4:3]=0.
4. HOLD_CYCLES=16: mouse_act every 8 clocks with stick_act=1 → zap_mode stays 0; stop mouse → zap_mode=1 on the clock after counter reaches 16.
5. In OWN_STICK with stick_act=1 continuously and mouse_act pulses → zap_mode stays 1; stick_act=0 for 16 clocks then mouse_act → zap_mode=0 next clock.
6. Assert reset mid-read-sequence and in OWN_STICK → all outputs 0, zap_mode=0, first post-reset $4016 read (strobe=0) returns 1.

Source files
------------

// File: rtl/zapper_port_ctrl.sv
// $4016/$4017 controller-port sequencer: two joypad shift registers, zapper
// substitution on port 2, and a mouse/analog-stick aim-source arbiter.
module zapper_port_ctrl #(
    parameter int unsigned HOLD_CYCLES = 1_000_000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_wr_4016,
    input  logic       cpu_din0,
    input  logic       cpu_rd_4016,
    input  logic       cpu_rd_4017,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
    input  logic       zap_en,
    input  logic       zap_light,
    input  logic       zap_trigger,
    input  logic       mouse_act,
    input  logic       stick_act,
    output logic       zap_mode,
    output logic [4:0] dout_4016,
    output logic [4:0] dout_4017
);

    typedef enum logic {
        OWN_MOUSE = 1'b0,
        OWN_STICK = 1'b1
    } aim_state_t;

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

    logic             strobe;
    logic [7:0]       sh1;
    logic [7:0]       sh2;
    logic [3:0]       rd1_cnt;
    logic [3:0]       rd2_cnt;

    aim_state_t       state;
    aim_state_t       state_next;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_next;
    logic [CNT_W-1:0] idle_cnt_inc;

    // Reads sample the registered strobe, so a read coincident with a write
    // sees the pre-write value.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe    <= 1'b0;
            sh1       <= 8'hFF;
            sh2       <= 8'hFF;
            rd1_cnt   <= '0;
            rd2_cnt   <= '0;
            dout_4016 <= '0;
            dout_4017 <= '0;
        end else begin
            if (cpu_wr_4016) begin
                strobe <= cpu_din0;
            end

            if (strobe) begin
                sh1     <= joy1;
                rd1_cnt <= '0;
            end else if (cpu_rd_4016) begin
                sh1 <= {1'b1, sh1[7:1]};
                if (rd1_cnt != 4'd8) begin
                    rd1_cnt <= rd1_cnt + 4'd1;
                end
            end
            if (cpu_rd_4016) begin
                dout_4016 <= {4'b0000, strobe ? joy1[0] : sh1[0]};
            end

            if (strobe) begin
                rd2_cnt <= '0;
            end
            if (cpu_rd_4017 && zap_en) begin
                // Zapper owns port 2 on this read; sh2 is left untouched.
                dout_4017 <= {zap_trigger, zap_light, 3'b000};
            end else begin
                if (strobe) begin
                    sh2 <= joy2;
                end else if (cpu_rd_4017) begin
                    sh2 <= {1'b1, sh2[7:1]};
                    if (rd2_cnt != 4'd8) begin
                        rd2_cnt <= rd2_cnt + 4'd1;
                    end
                end
                if (cpu_rd_4017) begin
                    dout_4017 <= {4'b0000, strobe ? joy2[0] : sh2[0]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OWN_MOUSE;
            idle_cnt <= '0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_cnt_next;
        end
    end

    assign idle_cnt_inc = (idle_cnt == HOLD) ? idle_cnt : idle_cnt + 1'b1;

    // Owner activity clears the counter before any transfer is considered.
    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt_inc;
        case (state)
            OWN_MOUSE: begin
                if (mouse_act) begin
                    idle_cnt_next = '0;
                end else if (stick_act && idle_cnt == HOLD) begin
                    state_next    = OWN_STICK;
                    idle_cnt_next = '0;
                end
            end
            OWN_STICK: begin
                if (stick_act) begin
                    idle_cnt_next = '0;
                end else if (mouse_act && idle_cnt == HOLD) begin
                    state_next    = OWN_MOUSE;
                    idle_cnt_next = '0;
                end
            end
            default: begin
                state_next    = OWN_MOUSE;
                idle_cnt_next = '0;
            end
        endcase
    end

    assign zap_mode = (state == OWN_STICK);

endmodule
